// File: rtl/bwd_pkg.sv
// Shared types for buffered_write_device.
//   state_t    : controller states (idle, load counter, count down)
//   PROC_CNT_W : width of the processing counter (PROC_CYCLES must fit)
package bwd_pkg;

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StWriting    = 2'd1,
    StProcessing = 2'd2
  } state_t;

  localparam int unsigned PROC_CNT_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request and data (ignored when full)
//   pop/rdata  : read request (ignored when empty); rdata shows the head entry
//   full/empty : occupancy flags derived from the registered count
//   count      : current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/buffered_write_device.sv
// Write-only sink: input FIFO feeding a fixed-latency item processor.
// Optional feature macro: BWD_DROP_CNT_EN adds a saturating drop_count port.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   write_enable : write request; data_in is pushed when write_ready is high
//   data_in      : write data
//   write_ready  : FIFO not full
//   busy         : FIFO not empty or an item is in flight
//   write_ack    : one-cycle pulse per completed item
//   ack_data     : data of the last completed item (held until next ack)
//   fill_level   : FIFO occupancy
//   overflow     : one-cycle pulse after a write was dropped
//   drop_count   : saturating count of dropped writes (BWD_DROP_CNT_EN only)
module buffered_write_device
  import bwd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PROC_CYCLES = 10,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_enable,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic                     write_ready,
  output logic                     busy,
  output logic                     write_ack,
  output logic [DATA_WIDTH-1:0]    ack_data,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow
`ifdef BWD_DROP_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]     drop_count
`endif
);

  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_rdata;

  state_t                state_q, state_d;
  logic [PROC_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] ack_data_q, ack_data_d;
  logic                  overflow_q, overflow_d;

  assign fifo_push = write_enable & ~fifo_full;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (data_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fill_level)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    ack_d      = 1'b0;
    ack_data_d = ack_data_q;
    fifo_pop   = 1'b0;
    // Drops are flagged even if a pop frees a slot this cycle.
    overflow_d = write_enable & fifo_full;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          work_d   = fifo_rdata;
          state_d  = StWriting;
        end
      end
      StWriting: begin
        cnt_d   = PROC_CNT_W'(PROC_CYCLES);
        state_d = StProcessing;
      end
      StProcessing: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - PROC_CNT_W'(1);
        end else begin
          ack_d      = 1'b1;
          ack_data_d = work_q;
          // Back-to-back: take the next item without passing through idle.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            work_d   = fifo_rdata;
            state_d  = StWriting;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      work_q     <= '0;
      ack_q      <= 1'b0;
      ack_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      ack_q      <= ack_d;
      ack_data_q <= ack_data_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef BWD_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow_d && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  assign write_ready = ~fifo_full;
  assign busy        = ~fifo_empty | (state_q != StIdle);
  assign write_ack   = ack_q;
  assign ack_data    = ack_data_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_buffered_write_device.sv
// Self-checking bench for buffered_write_device: table-driven bursts, directed
// corner sequences and random traffic, all cross-checked every cycle against a
// queue-based reference model.
module tb_buffered_write_device;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int P     = 10;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          we = 1'b0;
  logic [DW-1:0] din = '0;
  logic          ready, busy, ack, ovf;
  logic [DW-1:0] ack_data;
  logic [2:0]    fill;
`ifdef BWD_DROP_CNT_EN
  logic [CW-1:0] drop_count;
  logic [CW-1:0] drop_count0;
`endif

  // Second instance with zero processing time.
  logic          we0 = 1'b0;
  logic [DW-1:0] din0 = '0;
  logic          ready0, busy0, ack0, ovf0;
  logic [DW-1:0] ack_data0;
  logic [2:0]    fill0;

  buffered_write_device #(
    .DATA_WIDTH (DW), .DEPTH (DEPTH), .PROC_CYCLES (P), .CNT_WIDTH (CW)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .write_enable (we), .data_in (din),
    .write_ready (ready), .busy (busy), .write_ack (ack), .ack_data (ack_data),
    .fill_level (fill), .overflow (ovf)
`ifdef BWD_DROP_CNT_EN
    , .drop_count (drop_count)
`endif
  );

  buffered_write_device #(
    .DATA_WIDTH (DW), .DEPTH (DEPTH), .PROC_CYCLES (0), .CNT_WIDTH (CW)
  ) u_dut0 (
    .clk (clk), .rst_n (rst_n), .write_enable (we0), .data_in (din0),
    .write_ready (ready0), .busy (busy0), .write_ack (ack0), .ack_data (ack_data0),
    .fill_level (fill0), .overflow (ovf0)
`ifdef BWD_DROP_CNT_EN
    , .drop_count (drop_count0)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a queue of waiting items plus one in-flight item that
  // completes P+2 edges after it leaves the queue.
  logic [DW-1:0] m_q[$];
  bit            m_inflight = 0;
  logic [DW-1:0] m_item = '0;
  int            m_left = 0;
  bit            m_ack = 0;
  logic [DW-1:0] m_ack_data = '0;
  bit            m_ovf = 0;
  int            m_drops = 0;

  task automatic model_update();
    int sz;
    bit acc;
    if (!rst_n) begin
      m_q.delete();
      m_inflight = 0; m_left = 0; m_ack = 0; m_ack_data = '0; m_ovf = 0; m_drops = 0;
      return;
    end
    sz    = m_q.size();
    acc   = (we === 1'b1) && (sz < DEPTH);
    m_ovf = (we === 1'b1) && !acc;
    if (m_ovf) m_drops++;
    m_ack = 0;
    if (m_inflight) begin
      m_left--;
      if (m_left == 0) begin
        m_ack = 1; m_ack_data = m_item; m_inflight = 0;
      end
    end
    if (!m_inflight && sz > 0) begin
      m_item = m_q.pop_front(); m_inflight = 1; m_left = P + 2;
    end
    if (acc) m_q.push_back(din);
  endtask

  task automatic check_model();
    chk("ack", 32'(ack), 32'(m_ack));
    chk("ack_data", 32'(ack_data), 32'(m_ack_data));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("fill_level", 32'(fill), m_q.size());
    chk("write_ready", 32'(ready), 32'(m_q.size() < DEPTH));
    chk("busy", 32'(busy), 32'(m_q.size() > 0 || m_inflight));
`ifdef BWD_DROP_CNT_EN
    chk("drop_count", 32'(drop_count), (m_drops > 255) ? 255 : m_drops);
`endif
  endtask

  // Per-sequence recording of observed DUT events.
  logic [DW-1:0] rec_data[$];
  int            rec_time[$];
  bit            rec_busy[$];
  int            rec_ovf = 0;
  int            rec_max = 0;
  int            ack0_cnt = 0;
  int            ack0_time = 0;
  logic [DW-1:0] ack0_val = '0;
  bit            busy0_at_ack = 0;

  task automatic clear_rec();
    rec_data.delete(); rec_time.delete(); rec_busy.delete();
    rec_ovf = 0; rec_max = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    check_model();
    if (ack === 1'b1) begin
      rec_data.push_back(ack_data); rec_time.push_back(cyc); rec_busy.push_back(busy);
    end
    if (ovf === 1'b1) rec_ovf++;
    if (int'(fill) > rec_max) rec_max = int'(fill);
    if (ack0 === 1'b1) begin
      ack0_cnt++; ack0_time = cyc; ack0_val = ack_data0; busy0_at_ack = busy0;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_ack_data"}, 32'(ack_data), 0);
    chk({tag, "_overflow"}, 32'(ovf), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_fill"}, 32'(fill), 0);
    chk({tag, "_ready"}, 32'(ready), 1);
`ifdef BWD_DROP_CNT_EN
    chk({tag, "_drop_count"}, 32'(drop_count), 0);
`endif
  endtask

  task automatic drain(input string tag);
    we = 1'b0;
    for (int i = 0; i < 300 && (busy !== 1'b0 || ack === 1'b1); i++) step();
    step();
    chk({tag, "_drained"}, 32'(busy), 0);
  endtask

  typedef struct {
    bit            pre;       // queue one item (base-1) and let it start first
    int            n;         // consecutive writes
    logic [DW-1:0] base;      // data of first write, incrementing
    int            exp_acks;
    int            exp_ovf;
    int            exp_max_fill;
    int            exp_gap;   // cycles between consecutive acks
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    logic [DW-1:0] exp_d;
    tag = $sformatf("vec%0d", idx);
    clear_rec();
    if (v.pre) begin
      we = 1'b1; din = v.base - 8'd1; step();
      we = 1'b0; step(); step(); step();
    end
    for (int i = 0; i < v.n; i++) begin
      we = 1'b1; din = v.base + 8'(i); step();
    end
    drain(tag);
    chk({tag, "_acks"}, rec_data.size(), v.exp_acks);
    chk({tag, "_overflows"}, rec_ovf, v.exp_ovf);
    chk({tag, "_max_fill"}, rec_max, v.exp_max_fill);
    for (int i = 0; i < rec_data.size() && i < v.exp_acks; i++) begin
      exp_d = v.pre ? ((i == 0) ? v.base - 8'd1 : v.base + 8'(i - 1)) : v.base + 8'(i);
      chk($sformatf("%s_data%0d", tag, i), 32'(rec_data[i]), 32'(exp_d));
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), rec_time[i] - rec_time[i-1], v.exp_gap);
    end
  endtask

  initial begin
    int t0;
    int pct;

    vecs[0] = '{pre: 0, n: 1, base: 8'hAA, exp_acks: 1, exp_ovf: 0, exp_max_fill: 1, exp_gap: 12};
    vecs[1] = '{pre: 0, n: 4, base: 8'h11, exp_acks: 4, exp_ovf: 0, exp_max_fill: 3, exp_gap: 12};
    vecs[2] = '{pre: 0, n: 6, base: 8'h30, exp_acks: 5, exp_ovf: 1, exp_max_fill: 4, exp_gap: 12};
    vecs[3] = '{pre: 1, n: 6, base: 8'h60, exp_acks: 5, exp_ovf: 2, exp_max_fill: 4, exp_gap: 12};
    vecs[4] = '{pre: 0, n: 8, base: 8'h80, exp_acks: 5, exp_ovf: 3, exp_max_fill: 4, exp_gap: 12};

    // Reset from time zero (needs an actual falling edge).
    #2 rst_n = 1'b0;
    #1 check_reset("reset");
    step(); step();
    rst_n = 1'b1;
    step();

    // Single write: ack P+3 edges after the accept edge, busy low with it.
    clear_rec();
    we = 1'b1; din = 8'hAA; step(); t0 = cyc; we = 1'b0;
    for (int i = 0; i < 40 && rec_data.size() == 0; i++) step();
    chk("single_ack_seen", rec_data.size(), 1);
    if (rec_data.size() > 0) begin
      chk("single_latency", rec_time[0] - t0, P + 3);
      chk("single_ack_data", 32'(rec_data[0]), 32'h0000_00AA);
      chk("single_busy_at_ack", 32'(rec_busy[0]), 0);
    end
    drain("single");

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Random traffic at varying write densities.
    for (int ph = 0; ph < 6; ph++) begin
      pct = (ph % 3 == 0) ? 15 : ((ph % 3 == 1) ? 50 : 90);
      for (int i = 0; i < 100; i++) begin
        we  = ($urandom_range(0, 99) < pct);
        din = 8'($urandom);
        step();
      end
    end
    drain("random");

    // Reset while processing with two items queued.
    clear_rec();
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; din = 8'hC1 + 8'(i); step();
    end
    we = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("midrst_fill_before", 32'(fill), 2);
    rst_n = 1'b0;
    #1 check_reset("midrst");
    step(); step();
    rst_n = 1'b1;
    clear_rec();
    for (int i = 0; i < 40; i++) step();
    chk("midrst_no_ack", rec_data.size(), 0);
    check_reset("midrst_after");

    // Zero processing time instance.
    ack0_cnt = 0;
    we0 = 1'b1; din0 = 8'h5A; step(); t0 = cyc; we0 = 1'b0;
    for (int i = 0; i < 20 && ack0_cnt == 0; i++) step();
    chk("p0_ack_count", ack0_cnt, 1);
    chk("p0_latency", ack0_time - t0, 3);
    chk("p0_ack_data", 32'(ack0_val), 32'h0000_005A);
    chk("p0_busy_at_ack", 32'(busy0_at_ack), 0);

    // Continuous writes into a full FIFO: hundreds of drops.
    clear_rec();
    for (int i = 0; i < 320; i++) begin
      we = 1'b1; din = 8'($urandom); step();
    end
    drain("flood");
    chk("flood_overflows", rec_ovf, m_drops);
`ifdef BWD_DROP_CNT_EN
    chk("drop_saturated", 32'(drop_count), 32'h0000_00FF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
